bcd_accum_ctrl: RTL and testbench

BCD_ACCUM_CTRL -- requirements
Module: bcd_accum_ctrl

---
 rtl/bcd_accum_ctrl_pkg.sv | 22 ++
 rtl/bcd_accum_ctrl_x10.sv | 13 +
 rtl/bcd_accum_ctrl.sv | 126 ++++++++++++
 tb/tb_bcd_accum_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_accum_ctrl_pkg.sv
// Shared types and constants for the BCD-to-binary accumulator controller.
package bcd_accum_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DIGIT,
    MUL,
    ADD,
    DONE
  } state_e;

  localparam int W_DEFAULT = 13;
  localparam int BCD_MAX   = 9;

  // Largest accumulator value whose x10 product still fits in w bits.
  function automatic int mul_limit(input int w);
    return ((1 << w) - 1) / 10;
  endfunction

  localparam int MUL_LIMIT = mul_limit(W_DEFAULT);

endpackage

// File: rtl/bcd_accum_ctrl_x10.sv
// Combinational multiply-by-ten datapath: (x << 3) + (x << 1), truncated to W bits.
module bcd_accum_ctrl_x10
  import bcd_accum_ctrl_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y
);

  assign o_y = (i_x << 3) + (i_x << 1);

endmodule

// File: rtl/bcd_accum_ctrl.sv
// Serial BCD-to-binary converter: accepts NUM_DIGITS digits MSD first and
// accumulates acc*10+digit, flagging overflow and invalid digits.
module bcd_accum_ctrl
  import bcd_accum_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int W          = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   digit_in,
  input  logic         digit_valid,
  output logic         digit_ready,
  output logic [W-1:0] value,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic         bad_digit
);

  localparam logic [W-1:0] LIMIT      = W'(mul_limit(W));
  localparam logic [2:0]   LAST_COUNT = 3'(NUM_DIGITS);

  state_e       r_state;
  state_e       w_next;
  logic [W-1:0] r_acc;
  logic [W-1:0] r_prod;
  logic [3:0]   r_digit;
  logic [2:0]   r_count;
  logic         r_ovf;
  logic         r_bad;
  logic [W-1:0] w_prod;
  logic [W:0]   w_sum;
  logic [2:0]   w_count_inc;
  logic         w_take;
  logic         w_digit_bad;

  bcd_accum_ctrl_x10 #(.W(W)) u_x10 (
    .i_x (r_acc),
    .o_y (w_prod)
  );

  assign w_take      = (r_state == WAIT_DIGIT) && digit_valid;
  assign w_digit_bad = digit_in > 4'(BCD_MAX);
  assign w_sum       = {1'b0, r_prod} + (W+1)'(r_digit);
  assign w_count_inc = r_count + 3'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: the default assignment before the case keeps this combinational
  // block from inferring a latch on any unlisted path.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:       if (start) w_next = WAIT_DIGIT;
      WAIT_DIGIT: if (w_take) w_next = w_digit_bad ? DONE : MUL;
      MUL:        w_next = ADD;
      ADD:        w_next = (w_count_inc == LAST_COUNT) ? DONE : WAIT_DIGIT;
      DONE:       w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    digit_ready = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (r_state)
      IDLE:       busy        = 1'b0;
      WAIT_DIGIT: digit_ready = 1'b1;
      DONE:       done        = 1'b1;
      default:    ;
    endcase
  end

  // NOTE: datapath registers are reset as well, so value and both flags
  // read zero immediately after rst rather than holding stale results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_prod  <= '0;
      r_digit <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_bad   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_bad   <= 1'b0;
          end
        end
        WAIT_DIGIT: begin
          if (w_take) begin
            if (w_digit_bad) r_bad   <= 1'b1;
            else             r_digit <= digit_in;
          end
        end
        MUL: begin
          r_prod <= w_prod;
          if (r_acc > LIMIT) r_ovf <= 1'b1;
        end
        ADD: begin
          r_acc   <= w_sum[W-1:0];
          r_count <= w_count_inc;
          if (w_sum[W]) r_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign value     = r_acc;
  assign overflow  = r_ovf;
  assign bad_digit = r_bad;

endmodule

// File: tb/tb_bcd_accum_ctrl.sv
// Self-checking bench: directed vector table, reset/latency sequences and
// randomized conversions scored against an arithmetic reference model.
module tb_bcd_accum_ctrl;

  localparam int W  = 13;
  localparam int ND = 4;

  typedef struct {
    logic [3:0][3:0] digits;
    int              n;
    int              gap;
    bit              start_busy;
    int              exp_value;
    int              exp_ovf;
    int              exp_bad;
    int              exp_lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   digit_in;
  logic         digit_valid;
  logic         digit_ready, busy, done, overflow, bad_digit;
  logic [W-1:0] value;
  logic         d1_ready, d1_busy, d1_done, d1_ovf, d1_bad;
  logic [W-1:0] d1_value;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bcd_accum_ctrl #(.NUM_DIGITS(ND), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .digit_in(digit_in),
    .digit_valid(digit_valid), .digit_ready(digit_ready), .value(value),
    .busy(busy), .done(done), .overflow(overflow), .bad_digit(bad_digit)
  );

  bcd_accum_ctrl #(.NUM_DIGITS(1), .W(W)) dut1 (
    .clk(clk), .rst(rst), .start(start), .digit_in(digit_in),
    .digit_valid(digit_valid), .digit_ready(d1_ready), .value(d1_value),
    .busy(d1_busy), .done(d1_done), .overflow(d1_ovf), .bad_digit(d1_bad)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int d0, input int d1, input int d2, input int d3,
                              input int n, input int gap, input bit sb,
                              input int ev, input int eo, input int eb, input int el);
    vec_t v;
    v.digits[0] = 4'(d0); v.digits[1] = 4'(d1);
    v.digits[2] = 4'(d2); v.digits[3] = 4'(d3);
    v.n = n; v.gap = gap; v.start_busy = sb;
    v.exp_value = ev; v.exp_ovf = eo; v.exp_bad = eb; v.exp_lat = el;
    return v;
  endfunction

  // Reference: exact decimal value of the digit string, reduced mod 2^W at the end.
  function automatic vec_t model(input vec_t v);
    int tv = 0;
    int k  = 0;
    v.exp_bad = 0;
    for (int i = 0; i < v.n; i++) begin
      if (v.digits[i] > 4'd9) begin
        v.exp_bad = 1;
        k = i + 1;
        break;
      end
      tv = tv * 10 + int'(v.digits[i]);
    end
    v.exp_value = tv % (1 << W);
    v.exp_ovf   = (tv > (1 << W) - 1) ? 1 : 0;
    if (v.gap != 0)     v.exp_lat = -1;
    else if (v.exp_bad) v.exp_lat = 3 * k - 1;
    else                v.exp_lat = 3 * ND + 1;
    return v;
  endfunction

  // Cycle 0 carries start; digits are offered MSD first, with v.gap idle
  // cycles after each accepted digit.
  task automatic run_conv(input vec_t v, input string tag);
    int   cyc = 0, idx = 0, gapc = 0;
    int   done_cyc = -1, done_cnt = 0, since_acc = 99, ready_bad = 0;
    logic acc_now;
    for (int k = 0; k < 300; k++) begin
      start = (cyc == 0) || (v.start_busy && cyc == 5);
      if (idx < v.n && gapc == 0) begin
        digit_valid = 1'b1;
        digit_in    = v.digits[idx];
      end else begin
        digit_valid = 1'b0;
        digit_in    = 4'hF;
      end
      acc_now = digit_valid && digit_ready;
      tick();
      cyc++;
      if (acc_now) begin
        idx++;
        gapc      = v.gap;
        since_acc = 1;
      end else begin
        if (gapc > 0) gapc--;
        since_acc++;
      end
      if (since_acc <= 2 && digit_ready) ready_bad++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 3) break;
    end
    start       = 1'b0;
    digit_valid = 1'b0;
    check({tag, " done_seen"}, (done_cyc >= 0) ? 1 : 0, 1);
    check({tag, " done_pulses"}, done_cnt, 1);
    if (v.exp_lat >= 0) check({tag, " latency"}, done_cyc, v.exp_lat);
    check({tag, " value"}, int'(value), v.exp_value);
    check({tag, " overflow"}, int'(overflow), v.exp_ovf);
    check({tag, " bad_digit"}, int'(bad_digit), v.exp_bad);
    check({tag, " busy_after"}, int'(busy), 0);
    check({tag, " ready_in_mul_add"}, ready_bad, 0);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    int   extra;
    int   d1_done_cyc;

    // Directed vectors: digits, count, gap, start-while-busy, value, ovf, bad, latency.
    tbl.push_back(mk(1, 2, 3, 4,    4, 0, 0, 1234, 0, 0, 13));
    tbl.push_back(mk(9, 9, 9, 9,    4, 0, 0, 1807, 1, 0, 13));
    tbl.push_back(mk(1, 10, 0, 0,   2, 0, 0, 1,    0, 1, 5));
    tbl.push_back(mk(5, 0, 7, 2,    4, 3, 1, 5072, 0, 0, -1));
    tbl.push_back(mk(8, 1, 9, 2,    4, 0, 0, 0,    1, 0, 13));
    tbl.push_back(mk(8, 1, 9, 1,    4, 0, 0, 8191, 0, 0, 13));
    tbl.push_back(mk(0, 0, 0, 0,    4, 0, 0, 0,    0, 0, 13));
    tbl.push_back(mk(11, 0, 0, 0,   1, 0, 0, 0,    0, 1, 2));
    tbl.push_back(mk(9, 9, 9, 15,   4, 0, 0, 999,  0, 1, 11));

    rst = 1'b1; start = 1'b1; digit_valid = 1'b1; digit_in = 4'd5;
    tick();
    tick();
    check("rst value",       int'(value),       0);
    check("rst busy",        int'(busy),        0);
    check("rst done",        int'(done),        0);
    check("rst digit_ready", int'(digit_ready), 0);
    check("rst overflow",    int'(overflow),    0);
    check("rst bad_digit",   int'(bad_digit),   0);
    rst = 1'b0; start = 1'b0; digit_valid = 1'b0;
    tick();
    check("idle busy", int'(busy), 0);

    foreach (tbl[i]) run_conv(tbl[i], $sformatf("vec%0d", i));

    // Reset in MUL of the second digit, then a clean conversion.
    start = 1'b1; digit_valid = 1'b1; digit_in = 4'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    digit_in = 4'd2;
    tick();
    tick();
    check("midrst busy_before", int'(busy), 1);
    rst = 1'b1; start = 1'b1;
    tick();
    check("midrst value",       int'(value),       0);
    check("midrst busy",        int'(busy),        0);
    check("midrst done",        int'(done),        0);
    check("midrst digit_ready", int'(digit_ready), 0);
    check("midrst overflow",    int'(overflow),    0);
    check("midrst bad_digit",   int'(bad_digit),   0);
    rst = 1'b0; start = 1'b0; digit_valid = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) extra++;
    end
    check("midrst no_done_after", extra, 0);
    run_conv(mk(0, 0, 4, 2, 4, 0, 0, 42, 0, 0, 13), "after_rst");

    // Randomized conversions against the reference model.
    for (int r = 0; r < 40; r++) begin
      v.n = ND;
      for (int i = 0; i < ND; i++)
        v.digits[i] = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      v.gap        = $urandom_range(0, 2);
      v.start_busy = 1'($urandom_range(0, 1));
      v = model(v);
      run_conv(v, $sformatf("rnd%0d", r));
    end

    // Single-digit instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1; digit_valid = 1'b1; digit_in = 4'd7;
    d1_done_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
      if (d1_done && d1_done_cyc < 0) d1_done_cyc = c;
    end
    digit_valid = 1'b0;
    check("nd1 done_latency", d1_done_cyc, 4);
    check("nd1 value",        int'(d1_value), 7);
    check("nd1 overflow",     int'(d1_ovf),   0);
    check("nd1 busy_after",   int'(d1_busy),  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
